// File: rtl/sipo_shift_arb_if.sv
// sipo_shift_arb_if: requester, SIPO-pin and response signals of sipo_shift_arb
//   requester A/B : req_*, dir_*, word_* in; gnt_* out (one-cycle pulse)
//   SIPO pins     : sipo_load, sipo_dir, sipo_data out; sipo_q in
//   response      : busy, rsp_valid, rsp_data, rsp_id out
//   slave = the arbiter, master = the requesters plus SIPO side
interface sipo_shift_arb_if #(parameter int WIDTH = 4);
   logic             req_a;
   logic             req_b;
   logic             dir_a;
   logic             dir_b;
   logic [WIDTH-1:0] word_a;
   logic [WIDTH-1:0] word_b;
   logic             gnt_a;
   logic             gnt_b;
   logic             sipo_load;
   logic             sipo_dir;
   logic             sipo_data;
   logic [WIDTH-1:0] sipo_q;
   logic             busy;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_id;
   modport slave (
      input  req_a, req_b, dir_a, dir_b, word_a, word_b, sipo_q,
      output gnt_a, gnt_b, sipo_load, sipo_dir, sipo_data, busy, rsp_valid, rsp_data, rsp_id
   );
   modport master (
      output req_a, req_b, dir_a, dir_b, word_a, word_b, sipo_q,
      input  gnt_a, gnt_b, sipo_load, sipo_dir, sipo_data, busy, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/sipo_shift_arb.sv
// sipo_shift_arb: two-requester arbiter that serializes a word into a shared SIPO and returns its parallel output
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : sipo_shift_arb_if.slave (requests/grants, SIPO pins, response)
//   SIPO_ARB_FIXED_PRIO_EN defined -> A always wins a tie; undefined -> round-robin
module sipo_shift_arb #(
   parameter int WIDTH = 4
) (
   input logic           clock,
   input logic           reset,
   sipo_shift_arb_if.slave bus
);
   localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh;
   logic             pick_b;
   logic             dir_sel;
   logic [WIDTH-1:0] word_sel;
   logic [WIDTH-1:0] order;
`ifdef SIPO_ARB_FIXED_PRIO_EN
   assign pick_b = bus.req_b & ~bus.req_a;
`else
   logic last_b;
   assign pick_b = bus.req_b & (~bus.req_a | ~last_b);
`endif
   // order[0] is always the first bit on the wire, so SHIFT just streams LSB-first
   always_comb begin
      word_sel = pick_b ? bus.word_b : bus.word_a;
      dir_sel  = pick_b ? bus.dir_b : bus.dir_a;
      order    = word_sel;
      for (int i = 0; i < WIDTH; i++)
         order[i] = dir_sel ? word_sel[i] : word_sel[WIDTH-1-i];
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         sh            <= '0;
         bus.gnt_a     <= 1'b0;
         bus.gnt_b     <= 1'b0;
         bus.sipo_load <= 1'b0;
         bus.sipo_dir  <= 1'b0;
         bus.sipo_data <= 1'b0;
         bus.busy      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_id    <= 1'b0;
`ifndef SIPO_ARB_FIXED_PRIO_EN
         last_b        <= 1'b1;
`endif
      end else begin
         bus.gnt_a     <= 1'b0;
         bus.gnt_b     <= 1'b0;
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: if (bus.req_a | bus.req_b) begin
               state         <= SHIFT;
               cnt           <= '0;
               sh            <= order >> 1;
               bus.gnt_a     <= ~pick_b;
               bus.gnt_b     <= pick_b;
               bus.rsp_id    <= pick_b;
               bus.busy      <= 1'b1;
               bus.sipo_load <= 1'b1;
               bus.sipo_dir  <= dir_sel;
               bus.sipo_data <= order[0];
`ifndef SIPO_ARB_FIXED_PRIO_EN
               last_b        <= pick_b;
`endif
            end
            SHIFT: if (cnt == CW'(WIDTH - 1)) begin
               // last bit has been clocked into the SIPO; freeze it for one cycle
               state         <= DONE;
               cnt           <= '0;
               bus.sipo_load <= 1'b0;
               bus.sipo_data <= 1'b0;
            end else begin
               cnt           <= cnt + 1'b1;
               sh            <= sh >> 1;
               bus.sipo_data <= sh[0];
            end
            DONE: begin
               state         <= IDLE;
               bus.busy      <= 1'b0;
               bus.rsp_valid <= 1'b1;
               bus.rsp_data  <= bus.sipo_q;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
